stopwatch_uart_tx: RTL and testbench
====================================

# stopwatch_uart_tx

- Sends the stopwatch's current time to the UART transmit byte port as ASCII text: `MM:SS`, optionally followed by `\r\n`.
- Sits beside `stopwatch` in `top`:
  - takes the displayed BCD digits and a one-cycle send request;
  - drives `txdata`/`txclk` against the transmitter's `txready`.
- Complements the display path: the same time value goes out over the serial link instead of the seven-segment outputs.

## Interface
Parameters:
- `SEND_CRLF`, default 1: 1 sends 7 bytes (`d d : d d CR LF`); 0 sends 5 bytes.
- `SEP`, default 8'h3A: separator byte, `:`.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `send`  in  1  one-cycle request to transmit the current time.
- `time_bcd`  in  16  BCD digits `{min_tens, min_ones, sec_tens, sec_ones}`, one nibble each.
- `txready`  in  1  UART transmitter can accept a byte (level).
- `txdata`  out  8  byte being offered; registered.
- `txclk`  out  1  one-cycle strobe; `txdata` is valid in that cycle.
- `busy`  out  1  a message is in progress.
- `done`  out  1  one-cycle pulse after the last byte's strobe.

## Operation
- States: IDLE, WAIT_RDY, GAP.
- IDLE:
  - Leaves when `send` or `pending` is 1.
  - On leaving, captures `time_bcd` into a snapshot, clears `idx` to 0, clears `pending`, sets `busy`.
  - Goes to WAIT_RDY.
- WAIT_RDY:
  - When `txready`=1: registers `txdata` = byte[`idx`], asserts `txclk`, goes to GAP.
  - Otherwise holds; `txclk`=0 and `txdata` unchanged.
- GAP:
  - `txclk` returns to 0. `txready` is ignored this cycle (the transmitter drops it one cycle after a strobe).
  - If `idx` = LAST: `done`=1 for this cycle; `busy` and `done` fall together on the next edge; go to IDLE.
  - Otherwise: `idx`+1, go to WAIT_RDY.
  - LAST = 6 when `SEND_CRLF`=1, else 4.
- Byte sequence: 0 `min_tens`, 1 `min_ones`, 2 `SEP`, 3 `sec_tens`, 4 `sec_ones`, 5 8'h0D, 6 8'h0A.
- Digit encoding: nibble n ≤ 9 → 8'h30+n; n > 9 → 8'h3F (`?`).
- Digits always come from the snapshot. Changes on `time_bcd` during a message never affect that message.
- `send` while `busy`: sets `pending` (one deep; further requests merge into it). A new message starts in the IDLE cycle that follows `done`, with a fresh snapshot.
- `send` in the same cycle `done` is high: sets `pending`, not dropped.
- Reset at any point:
  - Aborts immediately; no further `txclk`.
  - All outputs return to reset values on the next edge.
  - `pending` and the snapshot are cleared.

## Timing
- Reset values: `txdata`=8'h00, `txclk`=0, `busy`=0, `done`=0; state IDLE; `pending`=0.
- Let `send` be sampled at edge k with `txready` held high:
  - `busy`=1 from edge k.
  - First `txclk` high in the cycle after edge k+1.
  - Each further byte every 2 cycles.
  - 7-byte message: last strobe after edge k+13; `done` after edge k+14; `busy`=0 after edge k+15.
- Throughput: at most one byte per 2 cycles.
- Each cycle `txready` stays low adds one cycle of delay per affected byte.
- `txclk` is never high on two consecutive cycles.
- `txdata` is stable from its strobe until the next strobe.

## Structure
- Package `uart_tx_pkg` holds:
  - state enum `tx_state_t` (IDLE, WAIT_RDY, GAP);
  - constants `ASCII_ZERO`=8'h30, `ASCII_QMARK`=8'h3F, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A.
- Sub-module `bcd_to_ascii`: combinational, 4-bit nibble → 8-bit ASCII digit or `?`. Instantiated once, fed by a mux over the snapshot nibbles.
- The FSM, `idx` counter, snapshot register and pending flag live in `stopwatch_uart_tx`.

## Test plan
- Reset and idle:
  - Stimulus: reset high 3 cycles, then low, `send`=0.
  - Required: `txdata`=0, `txclk`=0, `busy`=0, `done`=0 throughout.
- Basic message:
  - Stimulus: `time_bcd`=16'h1259, `txready`=1, `send` pulse.
  - Required: strobes carry 31 32 3A 35 39 0D 0A, 2 cycles apart; `done` once, at edge k+14.
- Backpressure and snapshot:
  - Stimulus: `txready` low 5 cycles before byte 2; `time_bcd` changed mid-message.
  - Required: bytes still 31 32 3A 35 39 0D 0A; strobe of byte 2 delayed 5 cycles; no strobe while `txready`=0.
- Queued request:
  - Stimulus: second `send` during byte 3 with `time_bcd`=16'h0001.
  - Required: first message completes; the next message starts immediately after with bytes 30 30 3A 30 31 0D 0A.
- Invalid digit, no CRLF:
  - Stimulus: `SEND_CRLF`=0, `time_bcd`=16'hA0F3.
  - Required: 3F 30 3A 3F 33; exactly 5 strobes.
- Reset mid-message:
  - Stimulus: reset asserted after byte 1's strobe, with a pending request.
  - Required: no further strobes; all outputs return to reset values; after release, no message starts without a new `send`.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and ASCII constants for the stopwatch UART text sender.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        GAP      = 2'd2
    } tx_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/bcd_to_ascii.sv
// Converts one BCD nibble to its ASCII digit; non-decimal nibbles become '?'.
module bcd_to_ascii
    import uart_tx_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Map 0..9 onto '0'..'9', anything else onto '?'
    always_comb begin
        ascii_o = ASCII_QMARK;
        if (nibble_i <= 4'd9) begin
            ascii_o = ASCII_ZERO + {4'd0, nibble_i};
        end else begin
            ascii_o = ASCII_QMARK;
        end
    end

endmodule

// File: rtl/stopwatch_uart_tx.sv
// Sends the stopwatch time as "MM:SS" (optionally followed by CR LF) to a
// byte-wide UART transmitter, one byte per strobe, throttled by txready.
module stopwatch_uart_tx
    import uart_tx_pkg::*;
#(
    parameter bit         SEND_CRLF = 1'b1,
    parameter logic [7:0] SEP       = 8'h3A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [15:0] time_bcd,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic        done
);

    // Index of the final byte of a message
    localparam logic [2:0] LAST = SEND_CRLF ? 3'd6 : 3'd4;

    tx_state_t   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] snap_q, snap_d;
    logic        pending_q, pending_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        txclk_q, txclk_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  nibble_s;
    logic [7:0]  digit_s;
    logic [7:0]  byte_s;

    // Pick the snapshot nibble that belongs to the current byte position
    always_comb begin
        nibble_s = 4'd0;
        case (idx_q)
            3'd0:    nibble_s = snap_q[15:12];
            3'd1:    nibble_s = snap_q[11:8];
            3'd3:    nibble_s = snap_q[7:4];
            3'd4:    nibble_s = snap_q[3:0];
            default: nibble_s = 4'd0;
        endcase
    end

    bcd_to_ascii u_bcd_to_ascii (
        .nibble_i (nibble_s),
        .ascii_o  (digit_s)
    );

    // Select the byte to offer at the current position
    always_comb begin
        byte_s = 8'h00;
        case (idx_q)
            3'd0, 3'd1, 3'd3, 3'd4: byte_s = digit_s;
            3'd2:                   byte_s = SEP;
            3'd5:                   byte_s = ASCII_CR;
            3'd6:                   byte_s = ASCII_LF;
            default:                byte_s = 8'h00;
        endcase
    end

    // Next-state and registered-output logic for the message sequencer
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        pending_d = pending_q;
        txdata_d  = txdata_q;
        txclk_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // A request raised while done was high is served right here
                if (send || pending_q) begin
                    snap_d    = time_bcd;
                    idx_d     = 3'd0;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = WAIT_RDY;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            WAIT_RDY: begin
                pending_d = pending_q | send;
                if (txready) begin
                    txdata_d = byte_s;
                    txclk_d  = 1'b1;
                    state_d  = GAP;
                end else begin
                    state_d  = WAIT_RDY;
                end
            end
            GAP: begin
                // txready is not looked at: the transmitter lowers it one cycle late
                pending_d = pending_q | send;
                if (idx_q == LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = WAIT_RDY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, snapshot and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            snap_q    <= 16'h0000;
            pending_q <= 1'b0;
            txdata_q  <= 8'h00;
            txclk_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            txdata_q  <= txdata_d;
            txclk_q   <= txclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = txclk_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_stopwatch_uart_tx.sv
// Directed bench for stopwatch_uart_tx: one CRLF instance, one without CRLF.
module tb_stopwatch_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        send0, send1;
    logic [15:0] time_bcd;
    logic        txready;
    logic [7:0]  txdata0, txdata1;
    logic        txclk0, txclk1, busy0, busy1, done0, done1;

    stopwatch_uart_tx #(.SEND_CRLF(1'b1), .SEP(8'h3A)) dut0 (
        .clk(clk), .reset(reset), .send(send0), .time_bcd(time_bcd),
        .txready(txready), .txdata(txdata0), .txclk(txclk0),
        .busy(busy0), .done(done0)
    );

    stopwatch_uart_tx #(.SEND_CRLF(1'b0), .SEP(8'h3A)) dut1 (
        .clk(clk), .reset(reset), .send(send1), .time_bcd(time_bcd),
        .txready(txready), .txdata(txdata1), .txclk(txclk1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic rdy_e = 1'b0;
    logic txclk0_prev = 1'b0;
    logic txclk1_prev = 1'b0;

    logic [7:0] d0[$];
    logic [7:0] d1[$];
    int c0[$];
    int c1[$];
    int dn0[$];
    int dn1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // edge counter and txready as seen by the most recent edge
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_e <= txready;
    end

    // strobe / done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (txclk0 === 1'b1) begin
            d0.push_back(txdata0);
            c0.push_back(cyc);
            chk("strobe_rdy0", {31'd0, rdy_e}, 32'd1);
            chk("strobe_gap0", {31'd0, txclk0_prev}, 32'd0);
        end
        if (txclk1 === 1'b1) begin
            d1.push_back(txdata1);
            c1.push_back(cyc);
            chk("strobe_rdy1", {31'd0, rdy_e}, 32'd1);
            chk("strobe_gap1", {31'd0, txclk1_prev}, 32'd0);
        end
        if (done0 === 1'b1) dn0.push_back(cyc);
        if (done1 === 1'b1) dn1.push_back(cyc);
        txclk0_prev = txclk0;
        txclk1_prev = txclk1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        d0.delete(); d1.delete(); c0.delete(); c1.delete();
        dn0.delete(); dn1.delete();
    endtask

    // compare n captured bytes (from queue position qi) against exp and the
    // 2-cycle cadence from edge k, with dly extra cycles from byte dpos on
    task automatic check_msg(input string tag, input bit inst, input int qi, input int n,
                             input logic [55:0] exp, input int k, input int dpos, input int dly);
        logic [7:0] got_d;
        int got_c;
        int ec;
        int sz;
        for (int i = 0; i < n; i++) begin
            sz = (inst == 1'b0) ? d0.size() : d1.size();
            if (qi + i < sz) begin
                got_d = (inst == 1'b0) ? d0[qi+i] : d1[qi+i];
                got_c = (inst == 1'b0) ? c0[qi+i] : c1[qi+i];
            end else begin
                got_d = 8'hEE;
                got_c = -1;
            end
            ec = k + 1 + 2 * i + ((i >= dpos) ? dly : 0);
            chk({tag, "_byte"}, {24'd0, got_d}, {24'd0, exp[55-8*i -: 8]});
            chk({tag, "_cyc"}, got_c, ec);
        end
    endtask

    int k;

    initial begin
        reset    = 1'b1;
        send0    = 1'b0;
        send1    = 1'b0;
        txready  = 1'b1;
        time_bcd = 16'h0000;

        // reset and idle
        repeat (3) begin
            tick;
            chk("rst_out0", {21'd0, txdata0, txclk0, busy0, done0}, 32'd0);
            chk("rst_out1", {21'd0, txdata1, txclk1, busy1, done1}, 32'd0);
        end
        reset = 1'b0;
        repeat (4) begin
            tick;
            chk("idle_out0", {21'd0, txdata0, txclk0, busy0, done0}, 32'd0);
            chk("idle_out1", {21'd0, txdata1, txclk1, busy1, done1}, 32'd0);
        end
        clear_q;

        // basic message
        time_bcd = 16'h1259;
        send0 = 1'b1; tick; send0 = 1'b0;
        k = cyc;
        chk("basic_busy_k", {31'd0, busy0}, 32'd1);
        repeat (15) tick;
        chk("basic_busy_end", {31'd0, busy0}, 32'd0);
        chk("basic_done_end", {31'd0, done0}, 32'd0);
        chk("basic_count", d0.size(), 32'd7);
        check_msg("basic", 1'b0, 0, 7, 56'h31323A35390D0A, k, 7, 0);
        chk("basic_done_n", dn0.size(), 32'd1);
        if (dn0.size() > 0) chk("basic_done_cyc", dn0[0], k + 14);
        clear_q;

        // backpressure before byte 2, digits changed mid-message
        send0 = 1'b1; tick; send0 = 1'b0;
        k = cyc;
        repeat (3) tick;
        time_bcd = 16'h9999;
        tick;
        txready = 1'b0;
        repeat (5) tick;
        txready = 1'b1;
        repeat (11) tick;
        chk("bp_count", d0.size(), 32'd7);
        check_msg("bp", 1'b0, 0, 7, 56'h31323A35390D0A, k, 2, 5);
        chk("bp_done_n", dn0.size(), 32'd1);
        if (dn0.size() > 0) chk("bp_done_cyc", dn0[0], k + 19);
        chk("bp_busy_end", {31'd0, busy0}, 32'd0);
        clear_q;

        // queued request during byte 3
        time_bcd = 16'h1259;
        send0 = 1'b1; tick; send0 = 1'b0;
        k = cyc;
        repeat (7) tick;
        time_bcd = 16'h0001;
        send0 = 1'b1; tick; send0 = 1'b0;
        repeat (7) tick;
        chk("q_busy_chain", {31'd0, busy0}, 32'd1);
        repeat (15) tick;
        chk("q_count", d0.size(), 32'd14);
        check_msg("q_first", 1'b0, 0, 7, 56'h31323A35390D0A, k, 7, 0);
        check_msg("q_second", 1'b0, 7, 7, 56'h30303A30310D0A, k + 15, 7, 0);
        chk("q_done_n", dn0.size(), 32'd2);
        if (dn0.size() > 1) begin
            chk("q_done0_cyc", dn0[0], k + 14);
            chk("q_done1_cyc", dn0[1], k + 29);
        end
        chk("q_busy_end", {31'd0, busy0}, 32'd0);
        clear_q;

        // invalid digits, no CRLF
        time_bcd = 16'hA0F3;
        send1 = 1'b1; tick; send1 = 1'b0;
        k = cyc;
        repeat (20) tick;
        chk("nocrlf_count", d1.size(), 32'd5);
        check_msg("nocrlf", 1'b1, 0, 5, {40'h3F303A3F33, 16'h0000}, k, 5, 0);
        chk("nocrlf_done_n", dn1.size(), 32'd1);
        if (dn1.size() > 0) chk("nocrlf_done_cyc", dn1[0], k + 10);
        chk("nocrlf_busy_end", {31'd0, busy1}, 32'd0);
        chk("nocrlf_other_idle", d0.size(), 32'd0);
        clear_q;

        // reset mid-message with a pending request
        time_bcd = 16'h1259;
        send0 = 1'b1; tick; send0 = 1'b0;
        k = cyc;
        repeat (3) tick;
        send0 = 1'b1; tick; send0 = 1'b0;
        reset = 1'b1;
        tick;
        chk("rmid_out", {21'd0, txdata0, txclk0, busy0, done0}, 32'd0);
        reset = 1'b0;
        repeat (30) tick;
        chk("rmid_count", d0.size(), 32'd2);
        check_msg("rmid", 1'b0, 0, 2, 56'h31320000000000, k, 7, 0);
        chk("rmid_done_n", dn0.size(), 32'd0);
        chk("rmid_idle", {21'd0, txdata0, txclk0, busy0, done0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
